// File: rtl/ring_code_decoder.sv
// ---------------------------------------------------------------------------
// ring_code_decoder
//
// Receive-side decoder and integrity monitor for ring (one-hot) and Johnson
// counter codes. Each enabled clock it samples count_in and decodes it to a
// binary state index. It then checks that the sample is a legal code word and
// that it is the correct successor of the previous one. From this it tracks
// a lock indication and keeps a saturating count of sequence errors.
//
// Parameters
//   N        code width in bits (N >= 2)
//   JOHNSON  0 = one-hot ring code (N states), 1 = Johnson code (2N states)
//   LOCK_CNT consecutive good transitions needed to declare lock (>= 1)
//   ERR_W    width of the error counter
//
// Ports
//   clk                 rising-edge clock
//   reset_ah_in         asynchronous, active-high reset
//   sample_en_in        sample count_in on this clock
//   count_in[N-1:0]     code word from the counter
//   index_out[IW-1:0]   decoded state index (holds on an illegal sample)
//   legal_out           last sample was a legal code word
//   locked_out          tracking a correctly advancing sequence
//   step_err_pulse_out  one-cycle pulse per sequence error while locked
//   err_count_out       saturating count of sequence errors
//
// Handshake: there is no valid/ready pair. A sample is consumed on every
// rising edge where sample_en_in is high. All outputs are registered and
// reflect that sample from the following cycle onward. When sample_en_in is
// low, every output holds its value, except the error pulse, which drops low.
//
// Optional feature macro: RING_DEC_HOLD_OK_EN
//   When defined, a repeated legal code seen while tracking or locked is a
//   hold. It causes no state change, no progress toward lock and no error.
//   This tolerates a source counter that is frozen. When the macro is not
//   defined, a repeated code is treated like any other non-successor.
// ---------------------------------------------------------------------------
module ring_code_decoder #(
  parameter int N        = 10,
  parameter int JOHNSON  = 0,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int M       = (JOHNSON != 0) ? 2 * N : N,
  localparam int IW      = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             sample_en_in,
  input  logic [N-1:0]     count_in,
  output logic [IW-1:0]    index_out,
  output logic             legal_out,
  output logic             locked_out,
  output logic             step_err_pulse_out,
  output logic [ERR_W-1:0] err_count_out
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // FSM state is kept in a named, enumerated register so that checkers can
  // bind to it by name.
  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [IW-1:0]    index_q, index_d;      // doubles as "previous index"
  logic             legal_q, legal_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] err_q, err_d;

  // Code word for state k. Ring: bit k set. Johnson: the low k bits are set
  // for k <= N. For k > N, the upper bits from position k-N upward are set.
  function automatic logic [N-1:0] code_word(input int k);
    logic [N-1:0] w;
    w = '0;
    for (int b = 0; b < N; b++) begin
      if (JOHNSON == 0)  w[b] = (b == k);
      else if (k <= N)   w[b] = (b < k);
      else               w[b] = (b >= k - N);
    end
    return w;
  endfunction

  // Decode by matching against every legal code word.
  logic          dec_legal;
  logic [IW-1:0] dec_index;

  always_comb begin
    dec_legal = 1'b0;
    dec_index = '0;
    for (int k = 0; k < M; k++) begin
      if (count_in == code_word(k)) begin
        dec_legal = 1'b1;
        dec_index = IW'(k);
      end
    end
  end

  // Expected successor of the previous index, wrapping M-1 -> 0.
  logic [IW-1:0] succ_index;
  logic          is_succ;
  logic          is_repeat;
  logic          hold_ok;

  assign succ_index = (index_q == IW'(M - 1)) ? '0 : index_q + IW'(1);
  assign is_succ    = dec_legal && (dec_index == succ_index);
  assign is_repeat  = dec_legal && (dec_index == index_q);

`ifdef RING_DEC_HOLD_OK_EN
  assign hold_ok = is_repeat;
`else
  assign hold_ok = 1'b0;
`endif

  // State register (asynchronous reset).
  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      index_q <= '0;
      legal_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      index_q <= index_d;
      legal_q <= legal_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    index_d = index_q;
    legal_d = legal_q;
    pulse_d = 1'b0;
    err_d   = err_q;

    if (sample_en_in) begin
      legal_d = dec_legal;
      // A legal sample always becomes the new previous index. On a hold it
      // is equal to the previous index, so the value is unchanged.
      if (dec_legal) index_d = dec_index;

      unique case (state_q)
        ST_UNLOCKED: begin
          if (dec_legal) begin
            state_d = ST_TRACK;
            good_d  = '0;
          end
        end

        ST_TRACK: begin
          if (!dec_legal) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end else if (is_succ) begin
            if (int'(good_q) + 1 >= LOCK_CNT) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else if (!hold_ok) begin
            // A legal non-successor reseeds tracking from this sample.
            good_d = '0;
          end
        end

        ST_LOCKED: begin
          if (!is_succ && !hold_ok) begin
            pulse_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            good_d  = '0;
            state_d = dec_legal ? ST_TRACK : ST_UNLOCKED;
          end
        end

        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    locked_out         = (state_q == ST_LOCKED);
    index_out          = index_q;
    legal_out          = legal_q;
    step_err_pulse_out = pulse_q;
    err_count_out      = err_q;
  end

endmodule

// File: tb/tb_ring_code_decoder.sv
// ---------------------------------------------------------------------------
// tb_ring_code_decoder
//
// Two decoder instances run side by side:
//   lane 0: N=4 Johnson code (8 states), ERR_W=2 (saturates at 3)
//   lane 1: N=6 ring code (6 states),    ERR_W=3 (saturates at 7)
// The reference model keeps a table of code words. It builds the table by
// stepping an ideal counter forward, then applies the lock/error rules to
// table lookups. After each clock edge, the driver pushes the expected
// output word into the queue for each lane. A monitor pops from the queues
// and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ring_code_decoder;

  localparam bit HOLD =
`ifdef RING_DEC_HOLD_OK_EN
    1'b1;
`else
    1'b0;
`endif
  localparam int LOCK = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] cnt_j = '0;
  logic [5:0] cnt_r = '0;
  logic [2:0] idx_j, idx_r;
  logic       legal_j, legal_r, locked_j, locked_r, pulse_j, pulse_r;
  logic [1:0] err_j;
  logic [2:0] err_r;

  ring_code_decoder #(.N(4), .JOHNSON(1), .LOCK_CNT(LOCK), .ERR_W(2)) dut_j (
    .clk(clk), .reset_ah_in(rst), .sample_en_in(en), .count_in(cnt_j),
    .index_out(idx_j), .legal_out(legal_j), .locked_out(locked_j),
    .step_err_pulse_out(pulse_j), .err_count_out(err_j)
  );

  ring_code_decoder #(.N(6), .JOHNSON(0), .LOCK_CNT(LOCK), .ERR_W(3)) dut_r (
    .clk(clk), .reset_ah_in(rst), .sample_en_in(en), .count_in(cnt_r),
    .index_out(idx_r), .legal_out(legal_r), .locked_out(locked_r),
    .step_err_pulse_out(pulse_r), .err_count_out(err_r)
  );

  // ---------------- reference model ----------------
  int ln_n[2]      = '{4, 6};
  int ln_m[2]      = '{8, 6};
  int ln_errmax[2] = '{3, 7};
  int ln_john[2]   = '{1, 0};
  int code_tab[2][16];

  int st[2];      // 0 unlocked, 1 tracking, 2 locked
  int good[2];
  int prev[2];
  int err[2];
  bit lg[2];
  bit pl[2];

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q_j[$];
  logic [18:0] exp_q_r[$];

  function automatic logic [18:0] pack(input int idx, input bit legal,
                                       input bit locked, input bit pulse,
                                       input int e);
    logic [7:0] i8;
    logic [7:0] e8;
    i8 = 8'(idx);
    e8 = 8'(e);
    return {i8, legal, locked, pulse, e8};
  endfunction

  task automatic build_tables();
    for (int ln = 0; ln < 2; ln++) begin
      int w;
      int mask;
      w    = 0;
      mask = (1 << ln_n[ln]) - 1;
      for (int k = 0; k < ln_m[ln]; k++) begin
        if (ln_john[ln] != 0) begin
          code_tab[ln][k] = w;
          // Johnson step: shift left, LSB takes the inverted old MSB.
          w = ((w << 1) | (((w >> (ln_n[ln] - 1)) & 1) ^ 1)) & mask;
        end else begin
          code_tab[ln][k] = 1 << k;
        end
      end
    end
  endtask

  function automatic int lookup(input int ln, input int code);
    int found;
    found = -1;
    for (int k = 0; k < ln_m[ln]; k++)
      if (code_tab[ln][k] == code) found = k;
    return found;
  endfunction

  task automatic model_reset();
    for (int ln = 0; ln < 2; ln++) begin
      st[ln] = 0; good[ln] = 0; prev[ln] = 0; err[ln] = 0;
      lg[ln] = 1'b0; pl[ln] = 1'b0;
    end
  endtask

  task automatic count_err(input int ln);
    if (err[ln] < ln_errmax[ln]) err[ln] = err[ln] + 1;
    pl[ln] = 1'b1;
  endtask

  task automatic model_step(input int ln, input bit e, input int code);
    int found;
    int succ;
    pl[ln] = 1'b0;
    if (!e) return;
    found = lookup(ln, code);
    succ  = (prev[ln] + 1) % ln_m[ln];
    if (found < 0) begin
      lg[ln] = 1'b0;
      if (st[ln] == 2) count_err(ln);
      st[ln]   = 0;
      good[ln] = 0;
    end else begin
      lg[ln] = 1'b1;
      if (st[ln] == 0) begin
        st[ln] = 1; good[ln] = 0; prev[ln] = found;
      end else if (found == succ) begin
        prev[ln] = found;
        if (st[ln] == 1) begin
          good[ln] = good[ln] + 1;
          if (good[ln] == LOCK) begin
            st[ln] = 2; good[ln] = 0;
          end
        end
      end else if (HOLD && found == prev[ln]) begin
        // frozen source tolerated
      end else begin
        if (st[ln] == 2) count_err(ln);
        st[ln] = 1; good[ln] = 0; prev[ln] = found;
      end
    end
  endtask

  function automatic logic [18:0] expected(input int ln);
    return pack(prev[ln], lg[ln], st[ln] == 2, pl[ln], err[ln]);
  endfunction

  // kind: 0 successor, 1 illegal, 2 repeat, 3 random legal, 5 index 0
  function automatic int pick_code(input int ln, input int kind);
    int c;
    case (kind)
      0: c = code_tab[ln][(prev[ln] + 1) % ln_m[ln]];
      1: begin
        c = $urandom_range(0, (1 << ln_n[ln]) - 1);
        while (lookup(ln, c) >= 0) c = $urandom_range(0, (1 << ln_n[ln]) - 1);
      end
      2: c = code_tab[ln][prev[ln]];
      3: c = code_tab[ln][$urandom_range(0, ln_m[ln] - 1)];
      default: c = code_tab[ln][0];
    endcase
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit e, input int kj, input int kr);
    int cj;
    int cr;
    @(negedge clk);
    cj = pick_code(0, kj);
    cr = pick_code(1, kr);
    en    = e;
    cnt_j = 4'(cj);
    cnt_r = 6'(cr);
    model_step(0, e, cj);
    model_step(1, e, cr);
    @(posedge clk);
    exp_q_j.push_back(expected(0));
    exp_q_r.push_back(expected(1));
  endtask

  task automatic check_zero(input string name);
    logic [18:0] aj;
    logic [18:0] ar;
    aj = pack(int'(idx_j), legal_j, locked_j, pulse_j, int'(err_j));
    ar = pack(int'(idx_r), legal_r, locked_r, pulse_r, int'(err_r));
    checks = checks + 2;
    if (aj !== 19'd0) begin
      failures = failures + 1;
      $display("FAIL %s lane_j got=%h exp=0", name, aj);
    end
    if (ar !== 19'd0) begin
      failures = failures + 1;
      $display("FAIL %s lane_r got=%h exp=0", name, ar);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    en = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero(name);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [18:0] e;
    logic [18:0] a;
    if (exp_q_j.size() > 0) begin
      e = exp_q_j.pop_front();
      a = pack(int'(idx_j), legal_j, locked_j, pulse_j, int'(err_j));
      checks = checks + 1;
      if (a !== e) begin
        failures = failures + 1;
        $display("FAIL lane_j t=%0t got=%h exp=%h", $time, a, e);
      end
    end
    if (exp_q_r.size() > 0) begin
      e = exp_q_r.pop_front();
      a = pack(int'(idx_r), legal_r, locked_r, pulse_r, int'(err_r));
      checks = checks + 1;
      if (a !== e) begin
        failures = failures + 1;
        $display("FAIL lane_r t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    build_tables();
    model_reset();
    #1 check_zero("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Lock from index 0, then run through the wrap point.
    drive(1'b1, 5, 5);
    repeat (3) drive(1'b1, 0, 0);
    repeat (6) drive(1'b1, 0, 0);
    // Disabled cycles: the codes must be ignored.
    repeat (3) drive(1'b0, 3, 1);

    // Errors with relock in between; the Johnson lane saturates at 3.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3, 3);
      repeat (3) drive(1'b1, 0, 0);
      if (i % 2 == 0) drive(1'b1, 1, 1);
      else            drive(1'b1, 2, 2);
      drive(1'b1, 0, 0);
    end

    // Relock, then reset mid-locked.
    drive(1'b1, 3, 3);
    repeat (4) drive(1'b1, 0, 0);
    do_reset("reset_locked");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int rj;
      int rr;
      bit e;
      int kj;
      int kr;
      e  = ($urandom_range(0, 9) != 0);
      rj = $urandom_range(0, 19);
      rr = $urandom_range(0, 19);
      kj = (rj < 14) ? 0 : (rj < 16) ? 1 : (rj < 18) ? 2 : 3;
      kr = (rr < 14) ? 0 : (rr < 16) ? 1 : (rr < 18) ? 2 : 3;
      drive(e, kj, kr);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && (exp_q_j.size() + exp_q_r.size()) > 0; i++)
      @(negedge clk);
    #1;
    if ((exp_q_j.size() + exp_q_r.size()) > 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL drain pending=%0d exp=0", exp_q_j.size() + exp_q_r.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
